// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline controller: owns the fetch PC and per-stage valid bits and
// raises stall/flush strobes. Define PIPE_PERF_CNT_EN to add stall/flush counters.

module pipeline_hazard_ctrl #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              PC_STEP    = 4,
    parameter int              REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  imem_ready,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [1:0]            id_rs_used,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_is_load,
    input  logic                  br_taken,
    input  logic [XLEN-1:0]       br_target,
    input  logic                  mem_busy,
    output logic [XLEN-1:0]       pc,
    output logic [4:0]            stage_valid,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  flush_id,
    output logic                  flush_ex
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_count
`endif
);

    localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(STEP - XLEN'(1));

    // One action per cycle, chosen in strict priority order.
    localparam logic [2:0] ACT_BUSY      = 3'd0;
    localparam logic [2:0] ACT_BRANCH    = 3'd1;
    localparam logic [2:0] ACT_LOADUSE   = 3'd2;
    localparam logic [2:0] ACT_FETCHWAIT = 3'd3;
    localparam logic [2:0] ACT_ADVANCE   = 3'd4;

    logic            br;
    logic            lu;
    logic            rs1_hit;
    logic            rs2_hit;
    logic [2:0]      action;
    logic [XLEN-1:0] pc_next;
    logic [4:0]      valid_next;

    // A load in EX writing a non-zero register that ID actually reads forces one bubble.
    assign rs1_hit = id_rs_used[0] && (id_rs1 == ex_rd);
    assign rs2_hit = id_rs_used[1] && (id_rs2 == ex_rd);
    assign br      = br_taken && stage_valid[2];
    assign lu      = stage_valid[1] && stage_valid[2] && ex_is_load &&
                     (ex_rd != '0) && (rs1_hit || rs2_hit);

    always_comb begin
        if (mem_busy)
            action = ACT_BUSY;
        else if (br)
            action = ACT_BRANCH;
        else if (lu)
            action = ACT_LOADUSE;
        else if (!imem_ready)
            action = ACT_FETCHWAIT;
        else
            action = ACT_ADVANCE;
    end

    always_comb begin
        pc_next    = pc;
        valid_next = stage_valid;
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        flush_id   = 1'b0;
        flush_ex   = 1'b0;
        case (action)
            ACT_BUSY: begin
                valid_next[4] = 1'b0;
                stall_if      = 1'b1;
                stall_id      = 1'b1;
            end
            ACT_BRANCH: begin
                pc_next    = br_target & ALIGN_MASK;
                valid_next = {stage_valid[3], stage_valid[2], 1'b0, 1'b0, imem_ready};
                flush_id   = 1'b1;
                flush_ex   = 1'b1;
            end
            ACT_LOADUSE: begin
                valid_next = {stage_valid[3], stage_valid[2], 1'b0, stage_valid[1:0]};
                stall_if   = 1'b1;
                stall_id   = 1'b1;
                flush_ex   = 1'b1;
            end
            ACT_FETCHWAIT: begin
                valid_next = {stage_valid[3:1], 1'b0, stage_valid[0]};
                stall_if   = 1'b1;
            end
            default: begin
                pc_next    = pc + STEP;
                valid_next = {stage_valid[3:0], 1'b1};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            stage_valid <= '0;
        end else begin
            pc          <= pc_next;
            stage_valid <= valid_next;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_if && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 32'd1;
            if ((action == ACT_BRANCH) && (flush_count != '1))
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule
